mem_initiator: RTL and testbench

Initiator side of the CPU's single-port memory bus. Accepts read requests from the instruction-fetch stage and read/write requests from the load/store stage, arbitrates them, and sequences each onto the 256 x 8 memory. The memory has a synchronous write and an asynchronous (combinational) read. Read data is returned to the originating stage through a valid/ready response channel.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/mem_rr_arbiter.sv | 31 +++
 rtl/mem_initiator.sv | 127 ++++++++++++
 tb/tb_mem_initiator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared widths and encodings for the CPU memory-bus initiator.
// State and grant enums are used by both the FSM and the round-robin arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-input round-robin arbiter between the fetch and load/store ports.
// On conflict the port not granted last time wins; requests are only accepted while en is high.
module mem_rr_arbiter
  import cpu_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic fetch_valid,
  input  logic data_valid,
  output logic fetch_ready,
  output logic data_ready
);

  grant_e last_grant_q;

  // Readies depend only on state, history and the competing valid, never on a response ready.
  assign fetch_ready = en & (~data_valid  | (last_grant_q == GNT_DATA));
  assign data_ready  = en & (~fetch_valid | (last_grant_q == GNT_FETCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_DATA;
    end else if (fetch_valid && fetch_ready) begin
      last_grant_q <= GNT_FETCH;
    end else if (data_valid && data_ready) begin
      last_grant_q <= GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Sequences fetch and load/store requests onto a single-port 256x8 memory
// (synchronous write, combinational read) and returns read data per port.
module mem_initiator
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  state_e              state_q;
  grant_e              port_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic                mem_write_enable_q;
  logic [DATA_W-1:0]   mem_write_data_q;
  logic                if_rsp_valid_q;
  logic                d_rsp_valid_q;
  logic [DATA_W-1:0]   if_rsp_data_q;
  logic [DATA_W-1:0]   d_rsp_data_q;
  logic                if_fire;
  logic                d_fire;

  mem_rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state_q == ST_IDLE),
    .fetch_valid (if_req_valid),
    .data_valid  (d_req_valid),
    .fetch_ready (if_req_ready),
    .data_ready  (d_req_ready)
  );

  assign if_fire = if_req_valid & if_req_ready;
  assign d_fire  = d_req_valid & d_req_ready;

  // The registered memory address/write-enable double as the latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      port_q             <= GNT_FETCH;
      mem_address_q      <= '0;
      mem_write_enable_q <= 1'b0;
      mem_write_data_q   <= '0;
      if_rsp_valid_q     <= 1'b0;
      d_rsp_valid_q      <= 1'b0;
      if_rsp_data_q      <= '0;
      d_rsp_data_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_fire) begin
            port_q             <= GNT_FETCH;
            mem_address_q      <= if_addr;
            mem_write_enable_q <= 1'b0;
            state_q            <= ST_ACCESS;
          end else if (d_fire) begin
            port_q             <= GNT_DATA;
            mem_address_q      <= d_addr;
            mem_write_enable_q <= d_req_we;
            if (d_req_we) begin
              mem_write_data_q <= d_wdata;
            end
            state_q            <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_write_enable_q <= 1'b0;
          if (mem_write_enable_q) begin
            state_q <= ST_IDLE;
          end else begin
            if (port_q == GNT_FETCH) begin
              if_rsp_data_q  <= mem_read_data;
              if_rsp_valid_q <= 1'b1;
            end else begin
              d_rsp_data_q  <= mem_read_data;
              d_rsp_valid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (if_rsp_valid_q && if_rsp_ready) begin
            if_rsp_valid_q <= 1'b0;
            state_q        <= ST_IDLE;
          end else if (d_rsp_valid_q && d_rsp_ready) begin
            d_rsp_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_address      = mem_address_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_write_data   = mem_write_data_q;
  assign if_rsp_valid     = if_rsp_valid_q;
  assign d_rsp_valid      = d_rsp_valid_q;
  assign if_rsp_data      = if_rsp_data_q;
  assign d_rsp_data       = d_rsp_data_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural 256x8 memory
// (synchronous write, combinational read) attached to the memory port.
module tb_mem_initiator;

  logic       clk;
  logic       rst_n;
  logic       if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [7:0] if_addr, if_rsp_data;
  logic       d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
  logic [7:0] d_addr, d_wdata, d_rsp_data;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_write_enable, busy;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;

  mem_initiator #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req_valid     (if_req_valid),
    .if_req_ready     (if_req_ready),
    .if_addr          (if_addr),
    .if_rsp_valid     (if_rsp_valid),
    .if_rsp_ready     (if_rsp_ready),
    .if_rsp_data      (if_rsp_data),
    .d_req_valid      (d_req_valid),
    .d_req_ready      (d_req_ready),
    .d_req_we         (d_req_we),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_ready      (d_rsp_ready),
    .d_rsp_data       (d_rsp_data),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] = mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full request/response sequence through one port, starting at a negedge in IDLE.
  task automatic issue(input string tag, input bit use_d, input bit we,
                       input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] exp);
    int cyc = 0;
    if (use_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    #1;
    while (!(use_d ? d_req_ready : if_req_ready) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    check({tag, "_accept"}, 32'(cyc < 20), 32'd1);
    @(negedge clk);
    if (use_d) d_req_valid = 1'b0; else if_req_valid = 1'b0;
    check({tag, "_addr"}, 32'(mem_address), 32'(addr));
    check({tag, "_we"}, 32'(mem_write_enable), 32'(we));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (we) check({tag, "_wdata"}, 32'(mem_write_data), 32'(wdata));
    @(negedge clk);
    if (we) begin
      check({tag, "_we_drop"}, 32'(mem_write_enable), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_no_rsp"}, 32'(d_rsp_valid), 32'd0);
    end else begin
      check({tag, "_rsp_v"}, 32'(use_d ? d_rsp_valid : if_rsp_valid), 32'd1);
      check({tag, "_rsp_d"}, 32'(use_d ? d_rsp_data : if_rsp_data), 32'(exp));
      check({tag, "_other_v"}, 32'(use_d ? if_rsp_valid : d_rsp_valid), 32'd0);
      if (use_d) d_rsp_ready = 1'b1; else if_rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, "_rsp_clr"}, 32'(use_d ? d_rsp_valid : if_rsp_valid), 32'd0);
      check({tag, "_done"}, 32'(busy), 32'd0);
      d_rsp_ready = 1'b0; if_rsp_ready = 1'b0;
    end
    $display("txn %s port=%s we=%0d addr=%02h wdata=%02h exp=%02h", tag,
             use_d ? "data" : "fetch", we, addr, wdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    if_req_valid = 0; if_addr = 0; if_rsp_ready = 0;
    d_req_valid = 0; d_req_we = 0; d_addr = 0; d_wdata = 0; d_rsp_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h1A;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_wdata", 32'(mem_write_data), 32'd0);
    check("rst_if_rsp", 32'({if_rsp_valid, if_rsp_data}), 32'd0);
    check("rst_d_rsp", 32'({d_rsp_valid, d_rsp_data}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_if_ready", 32'(if_req_ready), 32'd1);
    @(negedge clk);

    // Simultaneous requests: fetch first after reset, then strict alternation.
    if_req_valid = 1; if_addr = 8'h01;
    d_req_valid = 1; d_req_we = 0; d_addr = 8'h02;
    if_rsp_ready = 1; d_rsp_ready = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("arb_if_ready", 32'(if_req_ready), 32'(k % 2 == 0));
      check("arb_d_ready", 32'(d_req_ready), 32'(k % 2 == 1));
      @(negedge clk);
      check("arb_addr", 32'(mem_address), (k % 2 == 0) ? 32'h01 : 32'h02);
      @(negedge clk);
      if (k % 2 == 0) check("arb_if_data", 32'({if_rsp_valid, if_rsp_data}), 32'h111);
      else            check("arb_d_data", 32'({d_rsp_valid, d_rsp_data}), 32'h122);
      $display("txn arb grant %0d port=%s", k, (k % 2 == 0) ? "fetch" : "data");
      @(negedge clk);
    end
    if_req_valid = 0; d_req_valid = 0; if_rsp_ready = 0; d_rsp_ready = 0;
    @(negedge clk);

    issue("fetch03", 1'b0, 1'b0, 8'h03, 8'h00, 8'h1A);
    issue("store0f", 1'b1, 1'b1, 8'h0F, 8'h0B, 8'h00);
    issue("load0f", 1'b1, 1'b0, 8'h0F, 8'h00, 8'h0B);

    // Backpressure on the data response with a fetch waiting.
    d_req_valid = 1; d_req_we = 0; d_addr = 8'h0F;
    #1;
    check("bp_d_ready", 32'(d_req_ready), 32'd1);
    @(negedge clk);
    d_req_valid = 0; if_req_valid = 1; if_addr = 8'h03;
    #1;
    check("bp_access_if_ready", 32'(if_req_ready), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_d_valid", 32'(d_rsp_valid), 32'd1);
      check("bp_d_data", 32'(d_rsp_data), 32'h0B);
      check("bp_if_ready", 32'(if_req_ready), 32'd0);
      @(negedge clk);
    end
    d_rsp_ready = 1;
    #1;
    check("bp_ready_indep", 32'(if_req_ready), 32'd0);
    @(negedge clk);
    d_rsp_ready = 0;
    check("bp_d_clr", 32'(d_rsp_valid), 32'd0);
    check("bp_if_accept", 32'(if_req_ready), 32'd1);
    @(negedge clk);
    if_req_valid = 0;
    check("bp_fetch_addr", 32'(mem_address), 32'h03);
    @(negedge clk);
    check("bp_fetch_data", 32'({if_rsp_valid, if_rsp_data}), 32'h11A);
    if_rsp_ready = 1;
    @(negedge clk);
    if_rsp_ready = 0;
    $display("txn backpressure load 0f then fetch 03");

    // Reset during a load's response phase.
    d_req_valid = 1; d_req_we = 0; d_addr = 8'h0F;
    @(negedge clk);
    d_req_valid = 0;
    @(negedge clk);
    check("rl_pre_valid", 32'(d_rsp_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    check("rl_d_rsp", 32'({d_rsp_valid, d_rsp_data}), 32'd0);
    check("rl_busy", 32'(busy), 32'd0);
    check("rl_addr", 32'(mem_address), 32'd0);
    @(negedge clk);
    rst_n = 1;
    $display("txn reset during load response");
    issue("post_rl_load", 1'b1, 1'b0, 8'h0F, 8'h00, 8'h0B);

    // Reset during a store's memory access cycle.
    d_req_valid = 1; d_req_we = 1; d_addr = 8'h20; d_wdata = 8'h55;
    @(negedge clk);
    d_req_valid = 0;
    check("rs_pre_we", 32'(mem_write_enable), 32'd1);
    #2 rst_n = 0;
    #1;
    check("rs_we", 32'(mem_write_enable), 32'd0);
    check("rs_wdata", 32'(mem_write_data), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    $display("txn reset during store access");
    issue("post_rs_fetch", 1'b0, 1'b0, 8'h03, 8'h00, 8'h1A);

    issue("store_ff", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00);
    issue("load_00", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    issue("load_ff", 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
